// File: rtl/agu_pipe.sv
// agu_pipe: registered EX-stage address generation with valid/ready handshake and a sticky bad-address capture.
// Optional feature: define AGU_SPLIT_UNALIGNED_EN to split word-crossing accesses into two aligned beats.
module agu_pipe #(
    parameter int ADDR_W = 32,
    parameter int IMM_W  = 16,
    parameter int OFFS_W = 26
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_op_code,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [OFFS_W-1:0] i_offset,
    input  logic              i_out_ready,
    input  logic              i_exc_clr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_eff_addr,
    output logic [3:0]        o_be,
    output logic              o_last,
    output logic [1:0]        o_align,
    output logic [1:0]        o_exc_code,
    output logic [ADDR_W-1:0] o_bad_addr,
    output logic              o_exc_pending
);

    typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_FULL = 2'b01, ST_SPLIT0 = 2'b10} state_e;

    // Bits below the jump target field are replaced by {i_offset, 2'b00}
    localparam logic [ADDR_W-1:0] JMP_LO_MASK = {ADDR_W{1'b1}} >> (ADDR_W - OFFS_W - 2);

    state_e            state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] eff_q, eff_d, nxt_addr_q, nxt_addr_d, bad_q, bad_d;
    logic [3:0]        be_q, be_d, nxt_be_q, nxt_be_d;
    logic              last_q, last_d, pend_q, pend_d;
    logic [1:0]        align_q, align_d, exc_q, exc_d;

    logic [ADDR_W-1:0] imm_sext_s, req_addr_s;
    logic [3:0]        size_mask_s, req_be_s;
    logic [7:0]        mask_s;
    logic [1:0]        req_exc_s;
    logic              req_split_s, misal_s, accept_s, out_hs_s;

    assign o_ready  = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && i_out_ready);
    assign accept_s = i_valid && o_ready;
    assign out_hs_s = valid_q && i_out_ready;

    // Decode the incoming request into address, byte mask and exception code
    always_comb begin
        imm_sext_s = {{(ADDR_W-IMM_W){i_offset[IMM_W-1]}}, i_offset[IMM_W-1:0]};
        case (i_op_code)
            3'b001:  req_addr_s = i_base + imm_sext_s;
            3'b010:  req_addr_s = i_pc + (imm_sext_s << 2);
            3'b011:  req_addr_s = (i_pc & ~JMP_LO_MASK) | ({{(ADDR_W-OFFS_W){1'b0}}, i_offset} << 2);
            default: req_addr_s = i_base;
        endcase
        case (i_size)
            2'b00:   size_mask_s = 4'b0001;
            2'b01:   size_mask_s = 4'b0011;
            default: size_mask_s = 4'b1111;
        endcase
        mask_s      = {4'b0000, size_mask_s} << req_addr_s[1:0];
        misal_s     = ((i_size == 2'b01) && req_addr_s[0]) || (i_size[1] && (req_addr_s[1:0] != 2'b00));
        req_split_s = 1'b0;
        case (i_op_code)
            3'b000, 3'b001: begin
`ifdef AGU_SPLIT_UNALIGNED_EN
                req_be_s    = mask_s[3:0];
                req_exc_s   = 2'b00;
                req_split_s = (mask_s[7:4] != 4'b0000);
`else
                req_be_s    = misal_s ? 4'b0000 : mask_s[3:0];
                req_exc_s   = misal_s ? 2'b01 : 2'b00;
`endif
            end
            3'b010, 3'b011: begin
                req_be_s  = 4'b1111;
                req_exc_s = 2'b00;
            end
            3'b100: begin
                req_be_s  = 4'b1111;
                req_exc_s = (req_addr_s[1:0] != 2'b00) ? 2'b01 : 2'b00;
            end
            default: begin
                req_be_s  = 4'b0000;
                req_exc_s = 2'b10;
            end
        endcase
    end

    // Beat sequencing and bad-address capture next-state
    always_comb begin
        state_d    = state_q;
        eff_d      = eff_q;
        be_d       = be_q;
        last_d     = last_q;
        align_d    = align_q;
        exc_d      = exc_q;
        nxt_addr_d = nxt_addr_q;
        nxt_be_d   = nxt_be_q;
        bad_d      = bad_q;
        pend_d     = pend_q;
        if (accept_s) begin
            eff_d      = req_split_s ? {req_addr_s[ADDR_W-1:2], 2'b00} : req_addr_s;
            be_d       = req_be_s;
            last_d     = !req_split_s;
            align_d    = {(req_addr_s[1:0] != 2'b00), req_addr_s[0]};
            exc_d      = req_exc_s;
            nxt_addr_d = {req_addr_s[ADDR_W-1:2], 2'b00} + {{(ADDR_W-3){1'b0}}, 3'b100};
            nxt_be_d   = mask_s[7:4];
            state_d    = req_split_s ? ST_SPLIT0 : ST_FULL;
        end else if ((state_q == ST_SPLIT0) && i_out_ready) begin
            eff_d   = nxt_addr_q;
            be_d    = nxt_be_q;
            last_d  = 1'b1;
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && i_out_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
        valid_d = (state_d != ST_EMPTY);
        // A simultaneous clear lets a fresh fault overwrite the held one
        if (out_hs_s && (exc_q != 2'b00) && (!pend_q || i_exc_clr)) begin
            bad_d  = eff_q;
            pend_d = 1'b1;
        end else if (i_exc_clr) begin
            pend_d = 1'b0;
        end else begin
            pend_d = pend_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_EMPTY;
            valid_q    <= 1'b0;
            eff_q      <= {ADDR_W{1'b0}};
            be_q       <= 4'b0000;
            last_q     <= 1'b0;
            align_q    <= 2'b00;
            exc_q      <= 2'b00;
            nxt_addr_q <= {ADDR_W{1'b0}};
            nxt_be_q   <= 4'b0000;
            bad_q      <= {ADDR_W{1'b0}};
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            eff_q      <= eff_d;
            be_q       <= be_d;
            last_q     <= last_d;
            align_q    <= align_d;
            exc_q      <= exc_d;
            nxt_addr_q <= nxt_addr_d;
            nxt_be_q   <= nxt_be_d;
            bad_q      <= bad_d;
            pend_q     <= pend_d;
        end
    end

    assign o_valid       = valid_q;
    assign o_eff_addr    = eff_q;
    assign o_be          = be_q;
    assign o_last        = last_q;
    assign o_align       = align_q;
    assign o_exc_code    = exc_q;
    assign o_bad_addr    = bad_q;
    assign o_exc_pending = pend_q;

endmodule

// File: tb/tb_agu_pipe.sv
// Scoreboard bench for agu_pipe: a byte-level reference model queues expected beats, a monitor checks them.
module tb_agu_pipe;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op_code = 3'd0;
    logic [1:0]  i_size = 2'd0;
    logic [31:0] i_base = 32'd0;
    logic [31:0] i_pc = 32'd0;
    logic [25:0] i_offset = 26'd0;
    logic        i_out_ready = 1'b0;
    logic        i_exc_clr = 1'b0;
    logic        o_valid;
    logic [31:0] o_eff_addr;
    logic [3:0]  o_be;
    logic        o_last;
    logic [1:0]  o_align;
    logic [1:0]  o_exc_code;
    logic [31:0] o_bad_addr;
    logic        o_exc_pending;

    always #5 clk = ~clk;

    agu_pipe dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op_code(i_op_code), .i_size(i_size), .i_base(i_base), .i_pc(i_pc),
        .i_offset(i_offset), .i_out_ready(i_out_ready), .i_exc_clr(i_exc_clr),
        .o_valid(o_valid), .o_eff_addr(o_eff_addr), .o_be(o_be), .o_last(o_last),
        .o_align(o_align), .o_exc_code(o_exc_code), .o_bad_addr(o_bad_addr),
        .o_exc_pending(o_exc_pending)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        last;
        logic [1:0]  align;
        logic [1:0]  exc;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_bad = 32'd0;
    logic        m_pend = 1'b0;
    bit          stall_en = 1'b0;
    bit          sink_force = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: work out which bytes the request touches, then form beats from them
    function automatic void push_expected(input logic [2:0] op, input logic [1:0] size,
                                          input logic [31:0] base, input logic [31:0] pc,
                                          input logic [25:0] off);
        logic [15:0] imm;
        int          simm, lo, nb;
        logic [31:0] a;
        logic [3:0]  be0, be1;
        beat_t       b;
        imm  = off[15:0];
        simm = int'(imm);
        if (imm[15]) simm = simm - 65536;
        case (op)
            3'd1:    a = base + 32'(simm);
            3'd2:    a = pc + 32'(simm * 4);
            3'd3:    a = (pc & 32'hF000_0000) | ({6'd0, off} << 2);
            default: a = base;
        endcase
        lo = int'(a[1:0]);
        nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        b.addr  = a;
        b.align = {a[1:0] != 2'b00, a[0]};
        b.last  = 1'b1;
        b.exc   = 2'b00;
        b.be    = 4'b1111;
        if (op <= 3'd1) begin
            be0 = 4'b0000;
            be1 = 4'b0000;
            for (int k = lo; k < lo + nb; k++) begin
                if (k < 4) be0[k] = 1'b1;
                else be1[k-4] = 1'b1;
            end
`ifdef AGU_SPLIT_UNALIGNED_EN
            b.be = be0;
            if (be1 != 4'b0000) begin
                b.addr = {a[31:2], 2'b00};
                b.last = 1'b0;
                exp_q.push_back(b);
                b.addr = b.addr + 32'd4;
                b.be   = be1;
                b.last = 1'b1;
            end
`else
            if ((lo % nb) != 0) begin
                b.be  = 4'b0000;
                b.exc = 2'b01;
            end else begin
                b.be = be0;
            end
`endif
        end else if (op == 3'd4) begin
            b.exc = (lo != 0) ? 2'b01 : 2'b00;
        end else if (op >= 3'd5) begin
            b.be  = 4'b0000;
            b.exc = 2'b10;
        end
        exp_q.push_back(b);
    endfunction

    // Downstream sink: random ready, forced low while stalling, forced high while draining
    always @(negedge clk) begin
        if (stall_en) i_out_ready = 1'b0;
        else if (sink_force) i_out_ready = 1'b1;
        else i_out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares presented beats with the scoreboard and tracks the capture register
    bit    prev_st = 1'b0;
    beat_t snap;
    beat_t e;
    always begin
        @(negedge clk);
        #2;
        if (!i_rst_n) begin
            prev_st = 1'b0;
        end else begin
            chk("bad_addr", o_bad_addr, m_bad);
            chk("exc_pending", o_exc_pending, m_pend);
            if (prev_st)
                chk("stall_stable", {o_valid, o_eff_addr, o_be, o_last, o_align, o_exc_code},
                    {1'b1, snap.addr, snap.be, snap.last, snap.align, snap.exc});
            if (o_valid && !i_out_ready) chk("ready_stall", o_ready, 1'b0);
            if (!o_valid) chk("ready_idle", o_ready, 1'b1);
            if (o_valid && i_out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got addr %h with no request outstanding", o_eff_addr);
                    if (i_exc_clr) m_pend = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    chk("eff_addr", o_eff_addr, e.addr);
                    chk("be", o_be, e.be);
                    chk("last", o_last, e.last);
                    chk("align", o_align, e.align);
                    chk("exc_code", o_exc_code, e.exc);
                    if ((e.exc != 2'b00) && (!m_pend || i_exc_clr)) begin
                        m_bad  = e.addr;
                        m_pend = 1'b1;
                    end else if (i_exc_clr) begin
                        m_pend = 1'b0;
                    end
                end
            end else if (i_exc_clr) begin
                m_pend = 1'b0;
            end
            prev_st    = o_valid && !i_out_ready;
            snap.addr  = o_eff_addr;
            snap.be    = o_be;
            snap.last  = o_last;
            snap.align = o_align;
            snap.exc   = o_exc_code;
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] size, input logic [31:0] base,
                        input logic [31:0] pc, input logic [25:0] off, input logic clr);
        int n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_op_code = op; i_size = size; i_base = base; i_pc = pc;
        i_offset = off; i_exc_clr = clr;
        #1;
        while (!o_ready) begin
            n++;
            if (n > 60) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got o_ready 0 for %0d cycles expected 1", n);
                i_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        push_expected(op, size, base, pc, off);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_exc_clr = 1'b0;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_valid = 1'b0;
        i_exc_clr = 1'b1;
        @(negedge clk);
        i_exc_clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        sink_force = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
        end
        idle(2);
        sink_force = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_exc_clr = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_outputs", {o_valid, o_eff_addr, o_be, o_last, o_align, o_exc_code, o_bad_addr, o_exc_pending},
            64'd0);
        exp_q.delete();
        m_bad  = 32'd0;
        m_pend = 1'b0;
        i_rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_ready", o_ready, 1'b1);
    endtask

    initial begin
        do_reset();

        send(3'd1, 2'd0, 32'h0000_ABC0, 32'd0, 26'h000_FFFF, 1'b0);
        send(3'd2, 2'd3, 32'd0, 32'h0000_ABC0, 26'h000_FFFF, 1'b0);
        send(3'd3, 2'd3, 32'd0, 32'hEFEF_ABCD, 26'h3FF_FFFF, 1'b0);
        send(3'd0, 2'd1, 32'h0000_3001, 32'd0, 26'd0, 1'b0);
        send(3'd4, 2'd3, 32'h0000_5006, 32'd0, 26'd0, 1'b0);
        drain();

        pulse_clr();
        send(3'd1, 2'd3, 32'h0000_1002, 32'd0, 26'd0, 1'b0);
        drain();
`ifndef AGU_SPLIT_UNALIGNED_EN
        chk("first_capture", {o_exc_pending, o_bad_addr}, {1'b1, 32'h0000_1002});
`endif
        send(3'd1, 2'd3, 32'h0000_2001, 32'd0, 26'd0, 1'b0);
        drain();
`ifndef AGU_SPLIT_UNALIGNED_EN
        chk("sticky_capture", o_bad_addr, 32'h0000_1002);
`endif
        pulse_clr();
        idle(1);
        chk("clear_pending", o_exc_pending, 1'b0);

        send(3'd1, 2'd3, 32'h0000_4000, 32'd0, 26'd0, 1'b0);
        #1 stall_en = 1'b1;
        fork
            begin
                repeat (4) @(negedge clk);
                #1 stall_en = 1'b0;
            end
            send(3'd0, 2'd0, 32'h0000_4005, 32'd0, 26'd0, 1'b0);
        join
        send(3'd5, 2'd3, 32'h0000_7777, 32'd0, 26'd0, 1'b0);
        send(3'd7, 2'd0, 32'h0000_8888, 32'd0, 26'd0, 1'b0);
        drain();

        stall_en = 1'b1;
        send(3'd1, 2'd3, 32'h0000_1002, 32'd0, 26'd0, 1'b0);
        idle(1);
        do_reset();
        stall_en = 1'b0;
        idle(6);
        chk("no_beat_after_reset", o_valid, 1'b0);

        for (int i = 0; i < 400; i++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                 26'($urandom), ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/agu_pipe.md
# agu_pipe

Pipelined, parametrised address generation unit for the EX stage. Takes one request per cycle over a valid/ready handshake and registers the effective address, byte enables, alignment flags and exception code. It supports offset, branch, jump and register-jump modes. A sticky bad-address register captures the first faulting address for the exception handler. Optionally, it splits word or half accesses that cross a word boundary into two aligned beats.

## Interface

- ADDR_W, 32, address width
- IMM_W, 16, signed immediate width (low bits of i_offset)
- OFFS_W, 26, jump target width; ADDR_W >= OFFS_W+2 required

- i_clk  in  1  clock
- i_rst_n  in  1  synchronous, active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready at rising edge
- i_op_code  in  3  000 pass, 001 base+imm, 010 branch, 011 jump, 100 register jump; 101–111 illegal
- i_size  in  2  00 byte, 01 half, 11 word (10 treated as word)
- i_base  in  ADDR_W  base register value
- i_pc  in  ADDR_W  PC+4 of the instruction
- i_offset  in  OFFS_W  immediate/jump target
- i_out_ready  in  1  downstream ready
- i_exc_clr  in  1  clears the bad-address capture
- o_valid  out  1  output beat valid
- o_eff_addr  out  ADDR_W  effective (beat) address
- o_be  out  4  byte enables
- o_last  out  1  final beat of request
- o_align  out  2  bit0 = addr[0]; bit1 = |addr[1:0] (of unsplit effective address)
- o_exc_code  out  2  00 none, 01 misaligned, 10 illegal op
- o_bad_addr  out  ADDR_W  first captured faulting address
- o_exc_pending  out  1  capture register occupied

## Operation

- Address computation (all sums modulo 2^ADDR_W):
  - 000: i_base
  - 001: i_base + sext(imm)
  - 010: i_pc + (sext(imm) << 2)
  - 011: {i_pc[ADDR_W-1:OFFS_W+2], i_offset, 2'b00}
  - 100: i_base
  - Illegal opcodes: i_base
- Size/alignment rules:
  - Size applies to 000/001 only.
  - Modes 010/011 are word accesses, always aligned, be=1111.
  - Mode 100: be=1111; exc 01 if addr[1:0]!=0.
- Byte-enable mask m = (byte 0001 / half 0011 / word 1111) << addr[1:0], 8 bits wide.
- Without the split feature:
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned gives exc 01, be=0000.
  - Otherwise be=m[3:0].
- Illegal opcode: exc 10, be=0000, o_last=1.
- FSM states:
  - EMPTY: no beat held.
  - FULL: beat held; this is the last beat.
  - SPLIT0: first of two beats held.
- FSM transitions:
  - Accept in EMPTY/FULL goes to FULL or SPLIT0.
  - SPLIT0 with downstream handshake goes to FULL (second beat).
  - FULL with handshake and no new accept goes to EMPTY.
- o_ready = (state==EMPTY) || (state==FULL && i_out_ready); o_ready=0 in SPLIT0.
- Capture register:
  - Loads o_eff_addr on an output handshake with exc!=00 while o_exc_pending=0.
  - o_exc_pending sets on that load and stays set until i_exc_clr.
  - Later exceptions do not overwrite.
  - i_exc_clr and a new exception handshake in the same cycle: the new capture wins, pending stays 1.

## Timing

- Latency: request accepted at edge t appears on outputs after edge t; one beat per cycle at full throughput.
- Outputs are stable while o_valid && !i_out_ready.
- Reset (i_rst_n low at an edge):
  - o_valid, o_eff_addr, o_be, o_last, o_align, o_exc_code, o_bad_addr and o_exc_pending all go to 0.
  - State goes to EMPTY.
  - o_ready is 1 from the first cycle after reset.
- Reset during SPLIT0 drops the pending second beat.
- Reset has priority over i_valid and i_exc_clr.

## Configuration

- AGU_SPLIT_UNALIGNED_EN defined, for modes 000/001:
  - If m[3:0]!=0 and m[7:4]==0: one beat, be=m[3:0], exc 00. This includes half at addr 1 (be=0110).
  - If m[7:4]!=0: two beats.
    - Beat0: addr={eff[ADDR_W-1:2],00}, be=m[3:0], o_last=0.
    - Beat1: beat0 address +4 (wraps), be=m[7:4], o_last=1.
  - No misaligned exceptions in these modes; mode 100 still faults.
- Not defined: SPLIT0 is unreachable; misaligned requests produce exc 01 as above.

## Test plan

- Offset mode: op 001, size byte, base 0x0000ABC0, imm 0xFFFF -> next cycle o_valid=1, eff 0x0000ABBF, o_align=11, be=1000, exc 00, o_last=1.
- Branch/jump modes:
  - op 010, pc 0x0000ABC0, imm 0xFFFF -> eff 0x0000ABBC.
  - op 011, pc 0xEFEFABCD, offset 0x3FFFFFF -> eff 0xEFFFFFFC.
- Misaligned capture (macro off):
  - Word access at base 0x1002 -> exc 01, be 0000, o_bad_addr 0x1002, o_exc_pending=1.
  - A later word access at 0x2001 leaves o_bad_addr at 0x1002.
  - After i_exc_clr -> pending 0.
- Split (macro on): word access at 0x1002 -> beat0 eff 0x1000, be 1100, last 0, o_ready=0; then beat1 eff 0x1004, be 0011, last 1.
- Backpressure: i_out_ready low for 3 cycles with o_valid=1 -> outputs stable, o_ready=0, no request lost or duplicated; op 101 -> exc 10.
- Reset mid-split: i_rst_n low while in SPLIT0 -> next cycle o_valid=0, all outputs 0, second beat never issued.
